// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared widths, reset divisor and select-width helper for clock_divider_multi
package clkdiv_pkg;
    localparam int CNT_W_DEF = 32;
    typedef logic [CNT_W_DEF-1:0] div_t;
    localparam div_t DEFAULT_DIV_DEF = 32'd9000000;
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel with active/pending divisor, square wave and rise tick
//   clk, reset (async active-low), enable, wr (write strobe for this channel), clr (phase clear),
//   data (new divisor), sclk (divided clock), tick (one-cycle pulse on sclk rise)
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr,
    input  logic             clr,
    input  logic [CNT_W-1:0] data,
    output logic             sclk,
    output logic             tick
);
    logic [CNT_W-1:0] count, active, pending, next_div;
    logic             pend, term;
    assign term     = enable && count == active;
    // a write landing on the apply point bypasses the pending register
    assign next_div = wr ? data : pend ? pending : active;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            active  <= CNT_W'(DEFAULT_DIV);
            pending <= '0;
            pend    <= 1'b0;
            sclk    <= 1'b0;
            tick    <= 1'b0;
        end else if (clr) begin
            count  <= '0;
            active <= next_div;
            pend   <= 1'b0;
            sclk   <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= term && !sclk;
            if (term) begin
                count  <= '0;
                sclk   <= !sclk;
                active <= next_div;
                pend   <= 1'b0;
            end else begin
                if (enable) count <= count + CNT_W'(1);
                if (wr) begin
                    pending <= data;
                    pend    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH programmable clock dividers with glitch-free divisor updates
//   clk, reset (async active-low), enable[NUM_CH], div_wr/div_sel/div_data (divisor write),
//   div_ack (pulse after accepted write), sclk[NUM_CH], tick[NUM_CH]
//   CLKDIV_PHASE_ALIGN_EN adds sync_clr: zero all channels and apply pending divisors together
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int         SEL_W       = sel_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
`ifdef CLKDIV_PHASE_ALIGN_EN
    input  logic              sync_clr,
`endif
    input  logic [NUM_CH-1:0] enable,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_data,
    output logic              div_ack,
    output logic [NUM_CH-1:0] sclk,
    output logic [NUM_CH-1:0] tick
);
    logic clr;
`ifdef CLKDIV_PHASE_ALIGN_EN
    assign clr = sync_clr;
`else
    assign clr = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_ack <= 1'b0;
        else        div_ack <= div_wr && 32'(div_sel) < NUM_CH;
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .enable(enable[i]),
            .wr    (div_wr && 32'(div_sel) == i),
            .clr   (clr),
            .data  (div_data),
            .sclk  (sclk[i]),
            .tick  (tick[i])
        );
    end
endmodule
